// File: rtl/hall_call_if.sv
// Board-side bundle for the hall call register: switch bank, commit buttons,
// controller clear masks and the pending-request outputs.
interface hall_call_if #(
  parameter int FLOORS = 8
);
  logic [2*FLOORS-1:0] sw;
  logic                btnu;
  logic                btnd;
  logic                btnc;
  logic [FLOORS-1:0]   clr_up;
  logic [FLOORS-1:0]   clr_down;
  logic [FLOORS-1:0]   clr_car;
  logic [FLOORS-1:0]   up;
  logic [FLOORS-1:0]   down;
  logic [FLOORS-1:0]   elevator_btn;
  logic                req_pulse;
  logic                pending;

  modport master (
    output sw, btnu, btnd, btnc, clr_up, clr_down, clr_car,
    input  up, down, elevator_btn, req_pulse, pending
  );

  modport slave (
    input  sw, btnu, btnd, btnc, clr_up, clr_down, clr_car,
    output up, down, elevator_btn, req_pulse, pending
  );
endinterface

// File: rtl/hall_call_register.sv
// Per-floor hall/cabin request register: synchronised, debounced commit buttons
// OR the switch pattern into sticky request vectors cleared by the controller.
module hall_call_register #(
  parameter int FLOORS          = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic        clk,
  input logic        rst,
  hall_call_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]     CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  // No hall-up call from the top floor, no hall-down call from the ground floor.
  localparam logic [FLOORS-1:0] UP_MASK   = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DOWN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};
  localparam logic [FLOORS-1:0] NO_FLOORS = {FLOORS{1'b0}};

  // Channel order: 0 = hall up, 1 = hall down, 2 = cabin.
  logic [2:0]        btn_s;
  logic [2:0]        s1_r;
  logic [2:0]        s2_r;
  logic [2:0]        stable_r;
  logic [2:0]        commit_s;
  logic [CW-1:0]     cnt_r [3];

  logic [FLOORS-1:0] hall_sw_s;
  logic [FLOORS-1:0] car_sw_s;
  logic [FLOORS-1:0] up_set_s;
  logic [FLOORS-1:0] down_set_s;
  logic [FLOORS-1:0] car_set_s;
  logic [FLOORS-1:0] up_nxt_s;
  logic [FLOORS-1:0] down_nxt_s;
  logic [FLOORS-1:0] car_nxt_s;
  logic              new_req_s;

  logic [FLOORS-1:0] up_r;
  logic [FLOORS-1:0] down_r;
  logic [FLOORS-1:0] car_r;
  logic              pulse_r;

  assign btn_s     = {bus.btnc, bus.btnd, bus.btnu};
  assign hall_sw_s = bus.sw[2*FLOORS-1:FLOORS];
  assign car_sw_s  = bus.sw[FLOORS-1:0];

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= 3'b000;
      s2_r <= 3'b000;
    end else begin
      s1_r <= btn_s;
      s2_r <= s1_r;
    end
  end

  // Debounce: a new level must persist DEBOUNCE_CYCLES edges; any bounce restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s2_r[i] == stable_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_LAST) begin
          stable_r[i] <= s2_r[i];
          cnt_r[i]    <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Commit only on the edge where the debounced level rises.
  always_comb begin
    commit_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      commit_s[i] = (s2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_LAST) && s2_r[i];
    end
  end

  // Set vectors, next request state (set beats clear) and new-request detect.
  always_comb begin
    up_set_s   = NO_FLOORS;
    down_set_s = NO_FLOORS;
    car_set_s  = NO_FLOORS;
    if (commit_s[0]) begin
      up_set_s = hall_sw_s & UP_MASK;
    end else begin
      up_set_s = NO_FLOORS;
    end
    if (commit_s[1]) begin
      down_set_s = hall_sw_s & DOWN_MASK;
    end else begin
      down_set_s = NO_FLOORS;
    end
    if (commit_s[2]) begin
      car_set_s = car_sw_s;
    end else begin
      car_set_s = NO_FLOORS;
    end
    up_nxt_s   = (up_r   & ~bus.clr_up)   | up_set_s;
    down_nxt_s = (down_r & ~bus.clr_down) | down_set_s;
    car_nxt_s  = (car_r  & ~bus.clr_car)  | car_set_s;
    new_req_s  = |((up_set_s & ~up_r) | (down_set_s & ~down_r) | (car_set_s & ~car_r));
  end

  // Request registers and the new-request strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_r    <= NO_FLOORS;
      down_r  <= NO_FLOORS;
      car_r   <= NO_FLOORS;
      pulse_r <= 1'b0;
    end else begin
      up_r    <= up_nxt_s;
      down_r  <= down_nxt_s;
      car_r   <= car_nxt_s;
      pulse_r <= new_req_s;
    end
  end

  assign bus.up           = up_r;
  assign bus.down         = down_r;
  assign bus.elevator_btn = car_r;
  assign bus.req_pulse    = pulse_r;
  assign bus.pending      = |{up_r, down_r, car_r};
endmodule

// File: doc/hall_call_register.md
# hall_call_register

Parametrised successor to the elevator input stage. It turns the raw switch bank and the three push-buttons (up, down, cabin) into per-floor request bits held until the controller clears them. Each button is synchronised and debounced, and only a debounced press edge commits the switch pattern. The block sits between the board I/O and the elevator scheduling FSM.

## Interface
- FLOORS, 8, number of floors; switch bank width is 2*FLOORS; legal range 2..16.
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a button level must hold before it is accepted; minimum 1.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- sw  input  2*FLOORS  sw[2*FLOORS-1:FLOORS] selects hall floors for btnu/btnd; sw[FLOORS-1:0] selects cabin floors for btnc. Bit i = floor i.
- btnu  input  1  hall-up commit button, asynchronous, bouncy.
- btnd  input  1  hall-down commit button, asynchronous, bouncy.
- btnc  input  1  cabin commit button, asynchronous, bouncy.
- clr_up  input  FLOORS  synchronous clear mask for up.
- clr_down  input  FLOORS  synchronous clear mask for down.
- clr_car  input  FLOORS  synchronous clear mask for elevator_btn.
- up  output  FLOORS  pending hall-up requests.
- down  output  FLOORS  pending hall-down requests.
- elevator_btn  output  FLOORS  pending cabin requests.
- req_pulse  output  1  one-cycle strobe: at least one request bit went 0->1 this edge.
- pending  output  1  OR of all bits of up, down, elevator_btn (combinational from registers).

## Operation
- Per button, three identical channels: 2-flop synchroniser (s1, s2), debounced level `stable`, counter `cnt` of width clog2(DEBOUNCE_CYCLES+1).
- Channel per edge: if s2 == stable then cnt <= 0; else if cnt == DEBOUNCE_CYCLES-1 then stable <= s2, cnt <= 0; else cnt <= cnt+1.
- commit = (s2 != stable) && (cnt == DEBOUNCE_CYCLES-1) && s2, i.e. the edge at which stable rises. Falling acceptance of stable produces no action.
- On commit: btnu ORs sw[2F-1:F] into up; btnd ORs sw[2F-1:F] into down; btnc ORs sw[F-1:0] into elevator_btn. sw is sampled directly at the commit edge and must be static.
- Floor masks: up[FLOORS-1] and down[0] are never set; those switch bits are ignored for that direction.
- Per-bit next value: (cur & ~clr) | set. Set wins over a simultaneous clear of the same bit.
- Requests persist independently of button release; only clr_* or rst removes them.
- req_pulse <= |(set & ~cur) across all three vectors, with set masked as above. It is not asserted when a commit re-sets already-pending bits or sets nothing (all-zero switches).
- Simultaneous commits on several buttons in one edge are all applied.

## Timing
- Reset (async assert): s1, s2, stable, cnt, up, down, elevator_btn, req_pulse all 0; pending = 0. Release is synchronous to clk by the integrating design.
- Press latency: a button is first sampled high at edge 1. Requests and req_pulse are visible after edge DEBOUNCE_CYCLES+2 (edge 6 for default). No output changes earlier.
- A high pulse held for fewer than DEBOUNCE_CYCLES synchronised cycles commits nothing. Any bounce back to the stable level restarts the count.
- Clear latency: one edge; the bit reads 0 after the edge at which clr_* is high.
- Holding a button does not re-commit. A new commit requires release acceptance (DEBOUNCE_CYCLES low) and then a fresh press acceptance.
- Reset mid-debounce or mid-hold discards the count. A button still held after reset commits again after the full latency.

## Test plan
- Reset: assert rst mid-run with up=8'h0F -> all outputs 0 immediately (before next clk edge), pending=0.
- Clean press: F=8, D=4, sw=16'h2400, btnu held high from edge 1 -> up=8'h24 and req_pulse=1 for one cycle after edge 6; down=0; elevator_btn=0.
- Bounce reject: btnc high 3 cycles, low 1, high 3, then low -> elevator_btn stays 0 and req_pulse never fires. Then held 4+ cycles with sw[7:0]=8'h81 -> elevator_btn=8'h81.
- Edge floors: sw[15:8]=8'hFF, press btnu then btnd -> up=8'h7F, down=8'hFE, pending=1.
- Set/clear collision: up=8'h04 pending; clr_up=8'h04 asserted on the commit edge of btnu with sw[15:8]=8'h04 -> up stays 8'h04, req_pulse=0. Next cycle clr_up=8'h04 alone -> up=8'h00, pending=0.
- Hold no-repeat: btnd held 50 cycles with sw[15:8]=8'h10 and clr_down=8'h10 pulsed at cycle 20 -> down set once, cleared at cycle 20, not re-set until release and re-press.
